// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops words from a first-word-fall-through FIFO and serialises them onto txd
module uart_tx_fifo_drain #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  input  logic                 tx_en,
  input  logic [15:0]          baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 txd,
  output logic                 busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [15:0] cnt, div;
  logic [3:0] bit_cnt;
  logic [DATA_BITS-1:0] sh;
  logic pen, par, two, tick, last_stop, cap;
  assign tick = cnt == '0;
  assign last_stop = state == STOP && tick && bit_cnt == '0;
  assign cap = ~rst & tx_en & ~fifo_empty & (state == IDLE | last_stop);
  assign fifo_rd = cap;
  // frame sequencer: latches word and format at capture, then times and shifts each bit onto the registered line
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      txd <= 1'b1;
      busy <= 1'b0;
      cnt <= '0;
      div <= '0;
      bit_cnt <= '0;
      sh <= '0;
      pen <= 1'b0;
      par <= 1'b0;
      two <= 1'b0;
    end else if (cap) begin
      state <= START;
      txd <= 1'b0;
      busy <= 1'b1;
      cnt <= baud_div;
      div <= baud_div;
      sh <= fifo_data;
      pen <= parity_en;
      par <= ^fifo_data ^ parity_odd;
      two <= two_stop;
      bit_cnt <= '0;
    end else if (state == IDLE) begin
      txd <= 1'b1;
      busy <= 1'b0;
    end else if (!tick) begin
      cnt <= cnt - 1'b1;
    end else begin
      cnt <= div;
      case (state)
        START: begin
          state <= DATA;
          txd <= sh[0];
          sh <= sh >> 1;
          bit_cnt <= 4'(DATA_BITS - 1);
        end
        DATA: begin
          if (bit_cnt != '0) begin
            txd <= sh[0];
            sh <= sh >> 1;
            bit_cnt <= bit_cnt - 1'b1;
          end else if (pen) begin
            state <= PARITY;
            txd <= par;
          end else begin
            state <= STOP;
            txd <= 1'b1;
            bit_cnt <= {3'b0, two};
          end
        end
        PARITY: begin
          state <= STOP;
          txd <= 1'b1;
          bit_cnt <= {3'b0, two};
        end
        default: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            state <= IDLE;
            txd <= 1'b1;
            busy <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: random and directed stimulus checked cycle by cycle against a waveform-queue model
module tb_uart_tx_fifo_drain;
  localparam int DW = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic fifo_empty = 1'b1, tx_en = 1'b0, parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0;
  logic [15:0] baud_div = '0;
  logic fifo_rd, txd, busy;
  int n_chk = 0, n_fail = 0, n_rd = 0, n_busy = 0;
  logic [DW-1:0] q[$];
  bit exp_q[$];
  uart_tx_fifo_drain #(.DATA_BITS(DW)) dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .tx_en(tx_en), .baud_div(baud_div), .parity_en(parity_en), .parity_odd(parity_odd),
    .two_stop(two_stop), .txd(txd), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic push(input logic [DW-1:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
    fifo_data = q[0];
  endtask
  task automatic cyc();
    bit cap;
    int b;
    logic [DW-1:0] w;
    #1;
    cap = !rst && tx_en && q.size() > 0 && exp_q.size() <= 1;
    chk("fifo_rd", fifo_rd, cap);
    @(posedge clk);
    #1;
    if (rst) exp_q.delete();
    else if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (cap) begin
      w = q.pop_front();
      b = int'(baud_div) + 1;
      repeat (b) exp_q.push_back(1'b0);
      for (int i = 0; i < DW; i++) repeat (b) exp_q.push_back(w[i]);
      if (parity_en) repeat (b) exp_q.push_back(^w ^ parity_odd);
      repeat (two_stop ? 2 * b : b) exp_q.push_back(1'b1);
      n_rd++;
    end
    fifo_empty = q.size() == 0;
    fifo_data = fifo_empty ? '0 : q[0];
    if (busy) n_busy++;
    chk("txd", txd, exp_q.size() > 0 ? exp_q[0] : 1'b1);
    chk("busy", busy, exp_q.size() != 0);
  endtask
  task automatic run(input int n);
    repeat (n) cyc();
  endtask
  initial begin
    run(3);
    rst = 1'b0;
    baud_div = 16'd3;
    push(8'h55);
    tx_en = 1'b1;
    n_rd = 0;
    n_busy = 0;
    run(50);
    chk("t1_rd_count", n_rd, 1);
    chk("t1_busy_len", n_busy, 40);
    chk("t1_empty", fifo_empty, 1);
    baud_div = 16'd1;
    parity_en = 1'b1;
    two_stop = 1'b1;
    n_busy = 0;
    push(8'h07);
    run(30);
    chk("t2_even_len", n_busy, 24);
    parity_odd = 1'b1;
    n_busy = 0;
    push(8'h07);
    run(30);
    chk("t2_odd_len", n_busy, 24);
    parity_en = 1'b0;
    parity_odd = 1'b0;
    two_stop = 1'b0;
    baud_div = 16'd0;
    n_rd = 0;
    n_busy = 0;
    push(8'hA0);
    push(8'h0F);
    push(8'hFF);
    run(40);
    chk("t3_rd_count", n_rd, 3);
    chk("t3_busy_len", n_busy, 30);
    tx_en = 1'b0;
    n_rd = 0;
    push(8'h12);
    push(8'h34);
    run(100);
    chk("t4_no_rd", n_rd, 0);
    tx_en = 1'b1;
    baud_div = 16'd3;
    cyc();
    chk("t4_rd_same_cycle", n_rd, 1);
    run(5);
    tx_en = 1'b0;
    run(60);
    chk("t4_left_in_fifo", q.size(), 1);
    push(8'h3C);
    tx_en = 1'b1;
    run(10);
    rst = 1'b1;
    cyc();
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_txd", txd, 1);
    chk("t5_left_in_fifo", q.size(), 1);
    rst = 1'b0;
    run(50);
    n_busy = 0;
    push(8'hC3);
    push(8'h5A);
    run(10);
    baud_div = 16'd7;
    parity_en = 1'b1;
    run(150);
    chk("t6_busy_len", n_busy, 128);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0 && q.size() < 16) push(DW'($urandom));
      if ($urandom_range(0, 19) == 0) begin
        baud_div = 16'($urandom_range(0, 4));
        parity_en = 1'($urandom);
        parity_odd = 1'($urandom);
        two_stop = 1'($urandom);
      end
      if ($urandom_range(0, 29) == 0) tx_en = ~tx_en;
      rst = $urandom_range(0, 199) == 0;
      cyc();
    end
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
